freqmeter_ctrl: RTL and testbench

FREQMETER_CTRL -- requirements
Module: freqmeter_ctrl

---
 rtl/freqmeter_pkg.sv | 18 +
 rtl/freqmeter_ctrl_edge_sync.sv | 56 +++++
 rtl/freqmeter_ctrl.sv | 139 +++++++++++++
 tb/tb_freqmeter_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freqmeter_pkg.sv
// -----------------------------------------------------------------------------
// freqmeter_pkg
// Shared definitions for the frequency-meter controller.
//   state_t             : controller FSM states (IDLE, CLEAR, GATE, LOAD)
//   GATE_CYCLES_DEFAULT : default gate-window length in clk cycles
// -----------------------------------------------------------------------------
package freqmeter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        GATE  = 2'd2,
        LOAD  = 2'd3
    } state_t;

    localparam int GATE_CYCLES_DEFAULT = 1000;

endpackage : freqmeter_pkg

// File: rtl/freqmeter_ctrl_edge_sync.sv
// -----------------------------------------------------------------------------
// edge_sync
// Optional input synchronizer followed by a rising-edge detector for sig_in.
// Configuration macro: FREQMETER_SYNC_EN
//   defined   : sig_in -> meta flop -> sample flop -> prev flop (2-flop sync)
//   undefined : sig_in -> sample flop -> prev flop
// Ports:
//   clk    in  : clock
//   reset  in  : synchronous active-high reset, clears every flop
//   sig_in in  : external pulse train
//   rise   out : one-cycle pulse, sampled sig_in high while previous sample low
// -----------------------------------------------------------------------------
module edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic sig_in,
    output logic rise
);

    logic samp_reg;
    logic prev_reg;

`ifdef FREQMETER_SYNC_EN
    logic meta_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_reg <= 1'b0;
            samp_reg <= 1'b0;
        end else begin
            meta_reg <= sig_in;
            samp_reg <= meta_reg;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            samp_reg <= 1'b0;
        end else begin
            samp_reg <= sig_in;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_reg <= 1'b0;
        end else begin
            prev_reg <= samp_reg;
        end
    end

    // High for exactly one cycle per low-to-high transition of the sample.
    assign rise = samp_reg & ~prev_reg;

endmodule : edge_sync

// File: rtl/freqmeter_ctrl.sv
// -----------------------------------------------------------------------------
// freqmeter_ctrl
// Gate-window controller for a frequency meter driving a 3-digit BCD counter.
// Cycle: CLEAR (counter cleared) -> GATE (GATE_CYCLES cycles, edges counted)
// -> LOAD (display register loaded) -> CLEAR ... while run is high.
// Configuration macro: FREQMETER_SYNC_EN (adds a 2-flop synchronizer on sig_in
// inside edge_sync; en_cnt then arrives one cycle later).
// Parameter:
//   GATE_CYCLES : gate window length in clk cycles (>= 2)
// Ports:
//   clk         in  : clock
//   reset       in  : synchronous active-high reset
//   run         in  : 1 = measure continuously, 0 = idle
//   sig_in      in  : pulse train to be measured
//   carry_in    in  : carry from the downstream counter (count at 999)
//   en_cnt      out : count enable, one cycle per counted sig_in rise
//   cnt_reset   out : clear to downstream counter (IDLE, CLEAR)
//   cnt_load    out : one-cycle load strobe to display register (LOAD)
//   gate_active out : gate window open (GATE)
//   ovf         out : last completed window exceeded 999 counts
//   meas_valid  out : at least one window completed since reset
// -----------------------------------------------------------------------------
module freqmeter_ctrl
    import freqmeter_pkg::*;
#(
    parameter int GATE_CYCLES = GATE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic sig_in,
    input  logic carry_in,
    output logic en_cnt,
    output logic cnt_reset,
    output logic cnt_load,
    output logic gate_active,
    output logic ovf,
    output logic meas_valid
);

    localparam int CW = $clog2(GATE_CYCLES);
    localparam logic [CW-1:0] GATE_LAST = CW'(GATE_CYCLES - 1);

    state_t          state_reg;
    state_t          state_next;
    logic [CW-1:0]   gate_cnt_reg;
    logic            ovf_acc_reg;
    logic            ovf_reg;
    logic            meas_valid_reg;
    logic            rise;

    edge_sync u_edge_sync (
        .clk    (clk),
        .reset  (reset),
        .sig_in (sig_in),
        .rise   (rise)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Gate counter: held at zero outside GATE so every window starts fresh.
    always_ff @(posedge clk) begin
        if (reset || (state_reg != GATE)) begin
            gate_cnt_reg <= '0;
        end else begin
            gate_cnt_reg <= gate_cnt_reg + CW'(1);
        end
    end

    // Next-state and output decode
    always_comb begin
        state_next  = state_reg;
        en_cnt      = 1'b0;
        cnt_reset   = 1'b0;
        cnt_load    = 1'b0;
        gate_active = 1'b0;
        case (state_reg)
            IDLE: begin
                cnt_reset = 1'b1;
                if (run) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                cnt_reset  = 1'b1;
                state_next = run ? GATE : IDLE;
            end
            GATE: begin
                gate_active = 1'b1;
                en_cnt      = rise;
                // Dropping run aborts the window even on its last cycle.
                if (!run) begin
                    state_next = IDLE;
                end else if (gate_cnt_reg == GATE_LAST) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                cnt_load   = 1'b1;
                state_next = run ? CLEAR : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Overflow accumulator: the downstream counter wraps when it is enabled
    // while already at 999, which is exactly carry_in together with en_cnt.
    always_ff @(posedge clk) begin
        if (reset || (state_reg == CLEAR)) begin
            ovf_acc_reg <= 1'b0;
        end else if ((state_reg == GATE) && carry_in && en_cnt) begin
            ovf_acc_reg <= 1'b1;
        end
    end

    // Result flags only move on a completed window; aborts leave them alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_reg        <= 1'b0;
            meas_valid_reg <= 1'b0;
        end else if (state_reg == LOAD) begin
            ovf_reg        <= ovf_acc_reg;
            meas_valid_reg <= 1'b1;
        end
    end

    assign ovf        = ovf_reg;
    assign meas_valid = meas_valid_reg;

endmodule : freqmeter_ctrl

// File: tb/tb_freqmeter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_freqmeter_ctrl
// Self-checking bench for freqmeter_ctrl with GATE_CYCLES = 10.
// Reference model: once run is accepted the controller follows a fixed
// 12-cycle schedule (CLEAR, then repeating GATE x10, LOAD, CLEAR) derived from
// the cycle index; counted edges come from a history of sampled sig_in values
// delayed by the edge-detect latency (one extra cycle with FREQMETER_SYNC_EN).
// -----------------------------------------------------------------------------
module tb_freqmeter_ctrl;

    localparam int GC     = 10;
    localparam int PERIOD = GC + 2;
`ifdef FREQMETER_SYNC_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    localparam int P_IDLE  = 0;
    localparam int P_CLEAR = 1;
    localparam int P_GATE  = 2;
    localparam int P_LOAD  = 3;

    logic clk;
    logic reset;
    logic run;
    logic sig_in;
    logic carry_in;
    logic en_cnt;
    logic cnt_reset;
    logic cnt_load;
    logic gate_active;
    logic ovf;
    logic meas_valid;

    freqmeter_ctrl #(.GATE_CYCLES(GC)) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .sig_in      (sig_in),
        .carry_in    (carry_in),
        .en_cnt      (en_cnt),
        .cnt_reset   (cnt_reset),
        .cnt_load    (cnt_load),
        .gate_active (gate_active),
        .ovf         (ovf),
        .meas_valid  (meas_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Model state
    int cyc       = 2;
    bit hist [0:4095];
    bit m_running = 1'b0;
    int m_start   = 0;
    bit m_acc     = 1'b0;
    bit m_ovf     = 1'b0;
    bit m_valid   = 1'b0;

    // Position inside the 12-cycle schedule: 0..9 gate, 10 load, 11 clear.
    function automatic int jpos(input int c);
        int i;
        if (!m_running || c < m_start) return -1;
        i = c - m_start;
        if (i == 0) return PERIOD - 1;
        return (i - 1) % PERIOD;
    endfunction

    function automatic int phase_of(input int c);
        int j;
        j = jpos(c);
        if (j < 0)   return P_IDLE;
        if (j < GC)  return P_GATE;
        if (j == GC) return P_LOAD;
        return P_CLEAR;
    endfunction

    function automatic bit en_exp(input int c);
        return (phase_of(c) == P_GATE) && hist[c - LAT] && !hist[c - LAT - 1];
    endfunction

    task automatic check(input string tag, input int obs, input int expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, expv);
        end
    endtask

    // One clock cycle: model update at the rising edge, output check on the
    // falling edge.
    task automatic tick(input string tag);
        bit [5:0] exp_v;
        bit [5:0] obs_v;
        int ph;
        @(posedge clk);
        if (reset) begin
            m_running    = 1'b0;
            m_acc        = 1'b0;
            m_ovf        = 1'b0;
            m_valid      = 1'b0;
            hist[cyc+1]  = 1'b0;
            hist[cyc]    = 1'b0;
        end else begin
            ph = phase_of(cyc);
            if (ph == P_CLEAR) m_acc = 1'b0;
            if (ph == P_GATE && en_exp(cyc) && carry_in) m_acc = 1'b1;
            if (ph == P_LOAD) begin
                m_ovf   = m_acc;
                m_valid = 1'b1;
            end
            hist[cyc+1] = sig_in;
            if (m_running && !run) begin
                m_running = 1'b0;
            end else if (!m_running && run) begin
                m_running = 1'b1;
                m_start   = cyc + 1;
            end
        end
        cyc++;
        @(negedge clk);
        ph    = phase_of(cyc);
        exp_v = {en_exp(cyc), (ph == P_IDLE || ph == P_CLEAR), (ph == P_LOAD),
                 (ph == P_GATE), m_ovf, m_valid};
        obs_v = {en_cnt, cnt_reset, cnt_load, gate_active, ovf, meas_valid};
        n_assert++;
        assert (obs_v === exp_v) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d {en,rst,load,gate,ovf,valid} observed=%b expected=%b",
                   tag, cyc, obs_v, exp_v);
        end
    endtask

    task automatic wait_j(input int target, input string tag);
        int guard;
        guard = 0;
        while (jpos(cyc) != target && guard < 40) begin
            tick(tag);
            guard++;
        end
        if (guard >= 40) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s timeout waiting for schedule slot %0d observed=%0d", tag, target, jpos(cyc));
        end
    endtask

    // Runs one full window starting at its first gate cycle, toggling sig_in
    // every cycle. With with_carry, carry_in accompanies the first en_cnt;
    // otherwise carry_in is only raised on cycles without en_cnt.
    task automatic window_run(input bit with_carry, input string tag);
        bit used;
        int guard;
        used   = 1'b0;
        guard  = 0;
        sig_in = 1'b0;
        wait_j(0, tag);
        do begin
            if (with_carry) begin
                carry_in = en_exp(cyc) && !used;
                if (carry_in) used = 1'b1;
            end else begin
                carry_in = !en_exp(cyc);
            end
            sig_in = ~sig_in;
            tick(tag);
            guard++;
        end while (jpos(cyc) != PERIOD - 1 && guard < 20);
        carry_in = 1'b0;
    endtask

    initial begin
        int win_cnt;
        int first;
        int cnt;
        int k;
        int guard;
        int targets [4];

        reset    = 1'b1;
        run      = 1'b0;
        sig_in   = 1'b0;
        carry_in = 1'b0;

        // Reset held, then idle with run low and noise on sig_in
        repeat (3) tick("reset");
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            sig_in   = 1'($urandom_range(0, 1));
            carry_in = 1'($urandom_range(0, 1));
            tick("idle");
        end
        carry_in = 1'b0;

        // Steady counting: period-2 sig_in gives 5 pulses per window
        run     = 1'b1;
        win_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            sig_in = ~sig_in;
            tick("steady");
            if (phase_of(cyc) == P_GATE && en_cnt === 1'b1) win_cnt++;
            if (phase_of(cyc) == P_LOAD) begin
                check("steady_pulses_per_window", win_cnt, 5);
                win_cnt = 0;
            end
        end

        // Edge latency and level sensitivity: single rise, then held high
        sig_in = 1'b0;
        repeat (2) tick("latency_pre");
        wait_j(0, "latency_pre");
        sig_in = 1'b1;
        k      = cyc + 1;
        first  = -1;
        cnt    = 0;
        for (int i = 0; i < 20; i++) begin
            tick("level");
            if (en_cnt === 1'b1) begin
                cnt++;
                if (first < 0) first = cyc;
            end
        end
        check("latency_first_en", first, k + LAT);
        check("level_single_pulse", cnt, 1);

        // Boundary rises: last gate cycle, LOAD, CLEAR, first gate cycle
        targets = '{GC - 1, GC, PERIOD - 1, 0};
        foreach (targets[t]) begin
            sig_in = 1'b0;
            repeat (2) tick("boundary_pre");
            guard = 0;
            while (jpos(cyc + 1 + LAT) != targets[t] && guard < 30) begin
                tick("boundary_pre");
                guard++;
            end
            sig_in = 1'b1;
            tick("boundary");
            cnt = (en_cnt === 1'b1) ? 1 : 0;
            sig_in = 1'b0;
            for (int i = 0; i < 3; i++) begin
                tick("boundary");
                if (en_cnt === 1'b1) cnt++;
            end
            check($sformatf("boundary_slot_%0d", targets[t]), cnt, (targets[t] < GC) ? 1 : 0);
        end

        // Overflow: window with carry, window without, window with again
        window_run(1'b1, "ovf_win_n");
        check("ovf_after_carry_window", ovf, 1);
        check("valid_after_load", meas_valid, 1);
        window_run(1'b0, "ovf_win_n1");
        check("ovf_after_clean_window", ovf, 0);
        window_run(1'b1, "ovf_win_n2");
        check("ovf_set_again", ovf, 1);

        // Abort: run dropped on gate cycle 4
        wait_j(3, "abort_pre");
        run = 1'b0;
        tick("abort");
        check("abort_to_idle", {30'd0, gate_active, cnt_reset}, 1);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick("abort_idle");
            if (cnt_load === 1'b1) cnt++;
        end
        check("abort_no_load", cnt, 0);
        check("abort_flags_kept", {30'd0, ovf, meas_valid}, 3);

        // Reset mid-gate
        run = 1'b1;
        repeat (2) tick("rst_pre");
        wait_j(5, "rst_pre");
        reset = 1'b1;
        tick("rst_mid_gate");
        check("rst_mid_gate_outputs",
              {26'd0, en_cnt, cnt_reset, cnt_load, gate_active, ovf, meas_valid}, 6'b010000);
        reset = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            run      = ($urandom_range(0, 19) != 0);
            reset    = ($urandom_range(0, 99) == 0);
            sig_in   = 1'($urandom_range(0, 1));
            carry_in = 1'($urandom_range(0, 1));
            tick("random");
        end
        reset    = 1'b0;
        carry_in = 1'b0;
        repeat (2) tick("tail");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_freqmeter_ctrl
